// File: rtl/nn_pkg.sv
// Shared definitions for the MLP layer blocks: layer FSM states and
// two's-complement saturation bounds.
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Largest value representable in a signed w-bit word.
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Smallest value representable in a signed w-bit word.
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/requant_unit.sv
// Combinational requantization of one element: optional ReLU, round-half-up
// arithmetic right shift, then saturation to the narrow output width.
module requant_unit
   import nn_pkg::*;
#(
   parameter int WIDTH_IN  = 32,
   parameter int WIDTH_OUT = 8,
   parameter int SHIFT     = 8,
   parameter int RELU      = 1
) (
   input  logic signed [WIDTH_IN-1:0]  x,
   output logic signed [WIDTH_OUT-1:0] y
);

   localparam logic signed [WIDTH_IN:0] HI = (WIDTH_IN + 1)'(sat_max(WIDTH_OUT));
   localparam logic signed [WIDTH_IN:0] LO = (WIDTH_IN + 1)'(sat_min(WIDTH_OUT));

   // One guard bit so adding the rounding offset to the most positive input
   // cannot wrap.
   logic signed [WIDTH_IN:0] xe;
   logic signed [WIDTH_IN:0] r;

   assign xe = {x[WIDTH_IN-1], x};

   if (SHIFT > 0) begin : g_shift
      localparam logic signed [WIDTH_IN:0] HALF = (WIDTH_IN + 1)'(1) <<< (SHIFT - 1);
      assign r = (xe + HALF) >>> SHIFT;
   end else begin : g_noshift
      assign r = xe;
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      y = '0;
      if (RELU != 0 && x[WIDTH_IN-1]) begin
         y = '0;
      end else if (r > HI) begin
         y = HI[WIDTH_OUT-1:0];
      end else if (r < LO) begin
         y = LO[WIDTH_OUT-1:0];
      end else begin
         y = r[WIDTH_OUT-1:0];
      end
   end

endmodule

// File: rtl/dense_requant.sv
// Post-layer requantization: snapshots a dense layer's accumulator vector and
// converts it one neuron per cycle into the next layer's 8-bit activations.
module dense_requant
   import nn_pkg::*;
#(
   parameter int NEURON_NB = 32,
   parameter int WIDTH_IN  = 32,
   parameter int WIDTH_OUT = 8,
   parameter int SHIFT     = 8,
   parameter int RELU      = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           requant_go,
   input  logic [WIDTH_IN*NEURON_NB-1:0]  requant_in,
   output logic [WIDTH_OUT*NEURON_NB-1:0] requant_out,
   output logic                           requant_done
);

   localparam int             IDX_W = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURON_NB - 1);

   state_t                         state, next_state;
   logic                           capture, write;
   logic [IDX_W-1:0]               idx;
   logic [WIDTH_IN*NEURON_NB-1:0]  snap;
   logic signed [WIDTH_IN-1:0]     elem_in;
   logic signed [WIDTH_OUT-1:0]    elem_out;

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      write      = 1'b0;
      unique case (state)
         IDLE: begin
            if (requant_go) begin
               capture    = 1'b1;
               next_state = RUN;
            end
         end
         // A started run always completes; go is not looked at here.
         RUN: begin
            write = 1'b1;
            if (idx == LAST) next_state = DONE;
         end
         DONE: begin
            if (!requant_go) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         requant_done <= 1'b0;
      end else begin
         state        <= next_state;
         requant_done <= (next_state == DONE);
      end
   end

   assign elem_in = snap[idx*WIDTH_IN +: WIDTH_IN];

   requant_unit #(
      .WIDTH_IN (WIDTH_IN),
      .WIDTH_OUT(WIDTH_OUT),
      .SHIFT    (SHIFT),
      .RELU     (RELU)
   ) u_unit (
      .x(elem_in),
      .y(elem_out)
   );

   // NOTE: the snapshot is a plain register vector, not a RAM, so it is reset
   // along with everything else to give a defined state after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap        <= '0;
         requant_out <= '0;
         idx         <= '0;
      end else if (capture) begin
         snap        <= requant_in;
         requant_out <= '0;
         idx         <= '0;
      end else if (write) begin
         requant_out[idx*WIDTH_OUT +: WIDTH_OUT] <= elem_out;
         idx <= idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_dense_requant.sv
// Scoreboard bench for dense_requant: a ReLU instance and a signed instance,
// directed vectors with hand-computed results, handshake and reset checks.
module tb_dense_requant;

   localparam int N  = 4;
   localparam int WI = 32;
   localparam int WO = 8;
   localparam int SH = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            go_r, go_l;
   logic [WI*N-1:0] in_r, in_l;
   logic [WO*N-1:0] out_r, out_l;
   logic            done_r, done_l;

   int n_checks = 0;
   int n_fail   = 0;
   int rises_r  = 0;

   logic [WO*N-1:0] q_r[$];
   logic [WO*N-1:0] q_l[$];

   always #5 clk = ~clk;

   dense_requant #(.NEURON_NB(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .SHIFT(SH), .RELU(1)) dut_relu (
      .clk(clk), .reset(reset), .requant_go(go_r), .requant_in(in_r),
      .requant_out(out_r), .requant_done(done_r)
   );

   dense_requant #(.NEURON_NB(N), .WIDTH_IN(WI), .WIDTH_OUT(WO), .SHIFT(SH), .RELU(0)) dut_lin (
      .clk(clk), .reset(reset), .requant_go(go_l), .requant_in(in_l),
      .requant_out(out_l), .requant_done(done_l)
   );

   function automatic logic [WI*N-1:0] vin4(input int e0, input int e1, input int e2, input int e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic logic [WO*N-1:0] vout4(input byte e0, input byte e1, input byte e2, input byte e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_vec(input string name, input logic [WO*N-1:0] act, input logic [WO*N-1:0] exp);
      for (int i = 0; i < N; i++)
         check($sformatf("%s[%0d]", name, i), longint'($signed(act[i*WO +: WO])),
               longint'($signed(exp[i*WO +: WO])));
   endtask

   // Monitors: pop one expected vector on each rising edge of done.
   initial begin
      logic prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done_r && !prev) begin
            rises_r++;
            if (q_r.size() == 0) check("sb_relu_unexpected_done", 1, 0);
            else compare_vec("out_relu", out_r, q_r.pop_front());
         end
         prev = done_r;
      end
   end

   initial begin
      logic prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done_l && !prev) begin
            if (q_l.size() == 0) check("sb_lin_unexpected_done", 1, 0);
            else compare_vec("out_lin", out_l, q_l.pop_front());
         end
         prev = done_l;
      end
   end

   task automatic start(input bit lin, input logic [WI*N-1:0] vin, input logic [WO*N-1:0] exp,
                        input bit push);
      @(negedge clk);
      if (lin) begin
         in_l = vin;
         go_l = 1'b1;
         if (push) q_l.push_back(exp);
      end else begin
         in_r = vin;
         go_r = 1'b1;
         if (push) q_r.push_back(exp);
      end
   endtask

   // Counts rising edges from go until done is seen, bounded.
   task automatic wait_done(input bit lin, input string name);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(lin ? done_l : done_r) && n < 40);
      check(name, n, N + 1);
   endtask

   task automatic release_go(input bit lin, input string name);
      @(negedge clk);
      if (lin) go_l = 1'b0;
      else go_r = 1'b0;
      @(posedge clk);
      #1;
      check(name, lin ? done_l : done_r, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int r0;
      reset = 1'b1;
      go_r  = 1'b0;
      go_l  = 1'b0;
      in_r  = '0;
      in_l  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_relu", out_r, 0);
      check("reset_done_relu", done_r, 0);
      check("reset_out_lin", out_l, 0);
      check("reset_done_lin", done_l, 0);
      reset = 1'b0;

      // Rounding with ReLU
      start(0, vin4(384, 383, 127, 128), vout4(2, 1, 0, 1), 1);
      wait_done(0, "latency_round");
      release_go(0, "done_fall_round");

      // Saturation with ReLU
      start(0, vin4(100000, 32'h7FFFFFFF, -300, 0), vout4(127, 127, 0, 0), 1);
      wait_done(0, "latency_sat");
      release_go(0, "done_fall_sat");

      // Signed path without ReLU
      start(1, vin4(-300, -100000, -128, -129), vout4(-1, -128, 0, -1), 1);
      wait_done(1, "latency_signed");
      release_go(1, "done_fall_signed");

      // Go held for 20 cycles; input changed right after the capture edge
      r0 = rises_r;
      start(0, vin4(1000, -5, 256, 640), vout4(4, 0, 1, 3), 1);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) in_r = vin4(-1, 70000, -7, 12345);
         if (c >= N) check($sformatf("hold_done_c%0d", c), done_r, 1);
      end
      check("hold_single_run", rises_r - r0, 1);
      release_go(0, "done_fall_hold");
      repeat (3) @(posedge clk);
      #1;
      check("no_retrigger_after_drop", done_r, 0);

      // Reset after two elements have been written
      start(0, vin4(384, 383, 127, 128), '0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("partial_out_before_reset", out_r, 32'h0000_0102);
      reset = 1'b1;
      #1;
      check("midrun_reset_out", out_r, 0);
      check("midrun_reset_done", done_r, 0);
      in_r = vin4(-300, 100000, 384, 0);
      q_r.push_back(vout4(0, 127, 2, 0));
      @(negedge clk);
      reset = 1'b0;
      wait_done(0, "latency_after_reset");
      release_go(0, "done_fall_after_reset");

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sb_relu_drained", q_r.size(), 0);
      check("sb_lin_drained", q_l.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dense_requant.md
# dense_requant

Post-layer requantization stage between consecutive dense layers of the MLP. It takes the 32-bit signed accumulator outputs of a dense layer and applies optional ReLU, a rounding arithmetic right shift and saturation. It produces the narrow 8-bit activation vector that the next dense layer consumes as its input. Elements are processed serially, one neuron per cycle, under a go/done level handshake that matches the layer handshake.

## Interface
- NEURON_NB, 32, number of elements in the vector (equals the upstream layer's neuron count)
- WIDTH_IN, 32, bit width of each input element (signed)
- WIDTH_OUT, 8, bit width of each output element (signed)
- SHIFT, 8, arithmetic right-shift amount; valid range 0..WIDTH_IN-1
- RELU, 1, 1 clamps negative inputs to 0; 0 passes signed values through
- clk, input, 1, sole clock, rising edge
- reset, input, 1, asynchronous, active-high; clears all state
- requant_go, input, 1, level start request; connect to the upstream dense_done
- requant_in, input, WIDTH_IN*NEURON_NB, signed flattened vector; element i is at [(i+1)*WIDTH_IN-1 -: WIDTH_IN]
- requant_out, output, WIDTH_OUT*NEURON_NB, signed flattened result vector, same element packing as requant_in
- requant_done, output, 1, high while the complete result is valid

## Operation
- FSM states:
  - IDLE:
    - go=1 → snapshot requant_in into an internal register, clear requant_out to 0, idx←0, go to RUN.
  - RUN:
    - Each cycle, convert snapshot element idx and write it to output slot idx.
    - idx←idx+1.
    - After writing idx=NEURON_NB-1, go to DONE.
    - requant_go is ignored in RUN; a started run always completes.
  - DONE:
    - requant_done=1.
    - Stay in DONE while go=1; go=0 → IDLE.
- Per-element conversion x → y:
  - If RELU=1 and x<0: y=0.
  - Otherwise, if SHIFT>0: r = (x + 2^(SHIFT-1)) >>> SHIFT, computed in WIDTH_IN+1 bits so the maximum positive input cannot overflow. If SHIFT=0: r = x.
  - The rounding is round-half-up, i.e. floor toward −∞ after the offset is added.
  - Saturate r to [−2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)−1]. With RELU=1 the effective range is [0, 2^(WIDTH_OUT-1)−1].
- requant_out holds its value in IDLE and DONE. It changes only at a capture, which clears it, and during RUN writes.
- idx counter width: clog2(NEURON_NB), minimum 1 bit.

## Timing
- Reset values:
  - state=IDLE, idx=0.
  - requant_out all zeros, requant_done=0.
  - Snapshot register all zeros.
- Start latency:
  - go sampled high in IDLE at edge E0.
  - Element i is written at edge E0+1+i.
  - requant_done rises registered after edge E0+NEURON_NB. Total: NEURON_NB+1 cycles from go to done.
- requant_done falls on the edge after go is sampled low in DONE. The earliest new start is the edge after that.
- go held high continuously → exactly one run. No retrigger until go has been low in DONE.
- Changes on requant_in after the capture edge do not affect the current run.
- Reset asserted mid-RUN or in DONE → immediate return to reset values. A go still high after reset release starts a fresh run.
- NEURON_NB=1 → RUN lasts one cycle; done rises after edge E0+1.

## Structure
- Shared package nn_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - Saturation bound functions sat_max(W)=2^(W-1)−1 and sat_min(W)=−2^(W-1), reused by other layers.
- One sub-module: requant_unit, purely combinational, one element. Parameters WIDTH_IN, WIDTH_OUT, SHIFT, RELU. Input x, output y.
- The top level holds the FSM, idx counter, snapshot register and output register. It mux-selects snapshot element idx into the single requant_unit instance.

## Test plan
Bench configuration: NEURON_NB=4, WIDTH_IN=32, WIDTH_OUT=8, SHIFT=8.
- Rounding, RELU=1: inputs {384, 383, 127, 128} → outputs {2, 1, 0, 1}; done rises exactly 5 cycles after go.
- Saturation, RELU=1: inputs {100000, 0x7FFFFFFF, −300, 0} → outputs {127, 127, 0, 0}.
- Signed path, RELU=0: inputs {−300, −100000, −128, −129} → outputs {−1, −128, 0, −1}.
- Handshake:
  - Hold go high for 20 cycles → one run, done stays high for the whole hold.
  - Drop go → done low next cycle.
  - Change requant_in during RUN → results reflect the captured values only.
- Reset mid-run: assert reset after 2 elements are written → requant_out=0 and done=0 immediately. Release with go=1 → full correct run, done after 5 cycles.
